// File: rtl/fetch_pkg.sv
// fetch_pkg: redirect mode codes, fetch FSM states and the branch-taken rule
// shared by the prefetch unit and its bench.
package fetch_pkg;

    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_JMP = 2'b10;
    localparam logic [1:0] BR_JR  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_DROP = 2'b10
    } state_t;

    function automatic logic br_taken(input logic [1:0] mode, input logic z);
        return (mode == BR_BEQ) ? z : (mode == BR_BNE) ? !z : 1'b1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer with push, pop, flush and occupancy count.
// The head entry is read straight from registered storage.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);

    // When full, a simultaneous push lands in the slot the head is leaving.
    always_comb begin
        mem_d = mem_q;
        if (push && !flush) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
        count_d  = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC, instruction-memory req/ack handshake, redirects and
// a prefetch queue feeding decode over valid/ready.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              br_en,
    input  logic [1:0]        br_mode,
    input  logic              Z,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_base,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] addr
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_after;
    logic [ADDR_W-1:0]        target;
    logic [DATA_W+ADDR_W-1:0] head;
    logic                     taken, push, pop;

    assign taken       = br_en && br_taken(br_mode, Z);
    assign target      = (br_mode == BR_JR) ? br_base + br_target : br_target;
    assign push        = (state_q == ST_WAIT) && imem_ack && !taken;
    assign pop         = out_valid && out_ready;
    assign count_after = count + CW'(push) - CW'(pop);

    // A taken redirect wins; a live request becomes a stale one unless its ack is here now.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        if (taken) begin
            pc_d    = target;
            state_d = (state_q != ST_RUN && !imem_ack) ? ST_DROP : ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (count < CW'(DEPTH)) begin
                state_d = ST_WAIT;
                addr_d  = pc_q;
            end
        end else if (state_q == ST_WAIT && imem_ack) begin
            pc_d    = pc_q + ADDR_W'(PC_STEP);
            addr_d  = pc_d;
            state_d = (count_after < CW'(DEPTH)) ? ST_WAIT : ST_RUN;
        end else if (state_q == ST_DROP && imem_ack) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (DATA_W + ADDR_W)
    ) u_queue (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (push),
        .pop   (pop),
        .flush (taken),
        .wdata ({imem_data, imem_addr}),
        .rdata (head),
        .count (count)
    );

    assign imem_req  = (state_q == ST_WAIT);
    assign imem_addr = addr_q;
    assign out_valid = (count != '0);
    assign out_instr = head[ADDR_W +: DATA_W];
    assign out_pc    = head[ADDR_W-1:0];
    assign addr      = pc_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed scenarios with hand-derived expectations plus
// a randomized run against a queue-based reference model of the fetch rules.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        br_en, Z, imem_req, imem_ack, out_valid, out_ready;
    logic [1:0]  br_mode;
    logic [31:0] br_target, br_base, imem_addr, imem_data, out_instr, out_pc, addr;
    logic        auto_ack, ack_man;
    int          checks = 0;
    int          failures = 0;

    fetch_prefetch_unit dut (
        .Clock(Clock), .Reset(Reset), .br_en(br_en), .br_mode(br_mode), .Z(Z),
        .br_target(br_target), .br_base(br_base), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .addr(addr)
    );

    always #5 Clock = ~Clock;

    // Memory: word at address a is 0xA0+a; ack either mirrors req or is hand-driven.
    always_comb begin
        imem_ack  = auto_ack ? imem_req : ack_man;
        imem_data = 32'hA0 + imem_addr;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        br_en = 0; br_mode = 2'b00; Z = 0; br_target = '0; br_base = '0;
        out_ready = 0; auto_ack = 0; ack_man = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 0;
        tick();
        tick();
        Reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 0;
        #3;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        tick();
        Reset = 1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1; auto_ack = 1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL stream_first got=%b/%h exp=1/0", imem_req, imem_addr); end
        for (int k = 2; k <= 9; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(k-2) || out_instr !== 32'(32'hA0 + k - 2) || imem_req !== 1'b1 || imem_addr !== 32'(k-1)) begin
                failures++;
                $display("FAIL stream_%0d got v=%b pc=%h i=%h req=%b a=%h exp v=1 pc=%h i=%h req=1 a=%h",
                         k, out_valid, out_pc, out_instr, imem_req, imem_addr, 32'(k-2), 32'(32'hA0+k-2), 32'(k-1));
            end
        end
    endtask

    task automatic test_full();
        int nreq = 0;
        do_reset();
        out_ready = 0; auto_ack = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (imem_req) begin
                checks++; if (imem_addr !== 32'(nreq)) begin failures++; $display("FAIL full_addr got=%h exp=%h", imem_addr, 32'(nreq)); end
                nreq++;
            end
        end
        checks++; if (nreq != 4) begin failures++; $display("FAIL full_nreq got=%0d exp=4", nreq); end
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0 || addr !== 32'h4) begin
            failures++; $display("FAIL full_hold got req=%b v=%b pc=%h addr=%h exp 0/1/0/4", imem_req, out_valid, out_pc, addr); end
        out_ready = 1;
        tick();
        checks++; if (imem_req !== 1'b0 || out_pc !== 32'h1) begin failures++; $display("FAIL full_pop got req=%b pc=%h exp 0/1", imem_req, out_pc); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL full_reissue got=%b/%h exp=1/4", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drop();
        int n = 0;
        do_reset();
        out_ready = 1; auto_ack = 1;
        tick();
        while (!(imem_req && imem_addr == 32'h5) && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5) begin failures++; $display("FAIL drop_reach got=%b/%h exp=1/5", imem_req, imem_addr); end
        auto_ack = 0; ack_man = 0; out_ready = 0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5 || out_valid !== 1'b1 || out_pc !== 32'h4) begin
            failures++; $display("FAIL drop_wait got req=%b a=%h v=%b pc=%h exp 1/5/1/4", imem_req, imem_addr, out_valid, out_pc); end
        br_en = 1; br_mode = BR_BEQ; Z = 1; br_target = 32'h2;
        tick();
        br_en = 0;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || addr !== 32'h2) begin
            failures++; $display("FAIL drop_beq got v=%b req=%b addr=%h exp 0/0/2", out_valid, imem_req, addr); end
        ack_man = 1;
        tick();
        ack_man = 0;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL drop_discard got req=%b v=%b exp 0/0", imem_req, out_valid); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2) begin failures++; $display("FAIL drop_newreq got=%b/%h exp=1/2", imem_req, imem_addr); end
        out_ready = 1; auto_ack = 1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h2 || out_instr !== 32'hA2) begin
            failures++; $display("FAIL drop_data got v=%b pc=%h i=%h exp 1/2/a2", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        out_ready = 1; auto_ack = 1;
        repeat (4) tick();
        br_en = 1; br_mode = BR_BNE; Z = 1; br_target = 32'h40;
        tick();
        br_en = 0;
        checks++; if (imem_addr !== 32'h4 || out_valid !== 1'b1 || out_pc !== 32'h3) begin
            failures++; $display("FAIL bne_nt got a=%h v=%b pc=%h exp 4/1/3", imem_addr, out_valid, out_pc); end
        br_en = 1; br_mode = BR_JR; br_base = 32'h10; br_target = 32'hFFFF_FFFE;
        tick();
        br_en = 0;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || addr !== 32'h0E) begin
            failures++; $display("FAIL jr_redirect got req=%b v=%b addr=%h exp 0/0/e", imem_req, out_valid, addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0E) begin failures++; $display("FAIL jr_req got=%b/%h exp=1/e", imem_req, imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0E || out_instr !== 32'hAE || imem_addr !== 32'h0F) begin
            failures++; $display("FAIL jr_data got v=%b pc=%h i=%h a=%h exp 1/e/ae/f", out_valid, out_pc, out_instr, imem_addr); end
        br_en = 1; br_mode = BR_JMP; br_target = 32'h80;
        tick();
        br_en = 0;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || addr !== 32'h80) begin
            failures++; $display("FAIL jmp_redirect got req=%b v=%b addr=%h exp 0/0/80", imem_req, out_valid, addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL jmp_req got=%b/%h exp=1/80", imem_req, imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_instr !== 32'h120) begin
            failures++; $display("FAIL jmp_data got v=%b pc=%h i=%h exp 1/80/120", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 0; auto_ack = 1;
        repeat (4) tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3 || out_valid !== 1'b1) begin
            failures++; $display("FAIL mid_setup got req=%b a=%h v=%b exp 1/3/1", imem_req, imem_addr, out_valid); end
        auto_ack = 0;
        #2;
        Reset = 0;
        #1;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || addr !== 32'h0) begin
            failures++; $display("FAIL mid_reset got req=%b v=%b addr=%h exp 0/0/0", imem_req, out_valid, addr); end
        tick();
        Reset = 1; auto_ack = 1; out_ready = 1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA0) begin
            failures++; $display("FAIL mid_data got v=%b pc=%h i=%h exp 1/0/a0", out_valid, out_pc, out_instr); end
    endtask

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    task automatic test_random();
        ent_t        q[$];
        logic [31:0] m_pc = 0, m_addr = 0;
        logic        m_req = 0, m_drop = 0, tk, pre_req, pre_drop;
        int          c0, bad = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            out_ready = 1'($urandom % 2);
            br_en     = (($urandom % 10) == 0);
            br_mode   = 2'($urandom % 4);
            Z         = 1'($urandom % 2);
            br_target = (($urandom % 2) == 0) ? ($urandom % 64) : $urandom;
            br_base   = $urandom;
            ack_man   = (m_req || m_drop) ? (($urandom % 2) == 1) : (($urandom % 8) == 0);
            @(posedge Clock);
            c0 = q.size(); pre_req = m_req; pre_drop = m_drop;
            tk = br_en && (br_mode == BR_BEQ ? Z : br_mode == BR_BNE ? !Z : 1'b1);
            if (tk) begin
                q.delete();
                m_pc   = (br_mode == BR_JR) ? br_base + br_target : br_target;
                m_drop = (pre_req || pre_drop) && !ack_man;
                m_req  = 0;
            end else begin
                if (c0 != 0 && out_ready) void'(q.pop_front());
                if (pre_req && ack_man) begin
                    q.push_back('{32'hA0 + m_addr, m_addr});
                    m_pc  = m_pc + 1;
                    m_req = (q.size() < 4);
                    if (m_req) m_addr = m_pc;
                end else if (pre_drop && ack_man) begin
                    m_drop = 0;
                end else if (!pre_req && !pre_drop && c0 < 4) begin
                    m_req  = 1;
                    m_addr = m_pc;
                end
            end
            #1;
            checks++;
            if (imem_req !== m_req || (m_req && imem_addr !== m_addr) || addr !== m_pc || out_valid !== (q.size() != 0) ||
                (q.size() != 0 && (out_pc !== q[0].pc || out_instr !== q[0].instr))) begin
                failures++;
                if (bad < 10) $display("FAIL rand_cycle_%0d got req=%b a=%h pc=%h v=%b opc=%h oi=%h exp req=%b a=%h pc=%h v=%b opc=%h oi=%h",
                    c, imem_req, imem_addr, addr, out_valid, out_pc, out_instr, m_req, m_addr, m_pc, q.size() != 0,
                    (q.size() != 0) ? q[0].pc : 32'h0, (q.size() != 0) ? q[0].instr : 32'h0);
                bad++;
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_ack();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the single-register Fetch block. Holds the PC and issues instruction-memory requests over a req/ack handshake, supporting variable memory latency. Buffers fetched words in a DEPTH-entry prefetch queue feeding decode over valid/ready. Supports four redirect modes (BEQ, BNE, absolute jump, relative jump) with queue flush and discard of in-flight responses.

Parameters:
ADDR_W, 32, PC and address width
DATA_W, 32, instruction word width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
PC_STEP, 1, sequential PC increment (word-addressed)
RESET_PC, 0, PC value loaded on reset

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
br_en  in  1  redirect request this cycle
br_mode  in  2  00 BEQ (taken if Z=1), 01 BNE (taken if Z=0), 10 JMP absolute, 11 JR (br_base+br_target)
Z  in  1  zero flag from ALU
br_target  in  ADDR_W  absolute target, or signed offset for JR
br_base  in  ADDR_W  base address for JR
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address
imem_ack  in  1  response valid; data on imem_data
imem_data  in  DATA_W  instruction word
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  DATA_W  head instruction
out_pc  out  ADDR_W  address of head instruction
addr  out  ADDR_W  current PC (next address to fetch; legacy-compatible)

Behaviour:
- Reset (Reset=0, asynchronous) sets pc=RESET_PC, imem_req=0, out_valid=0, queue count=0, state=RUN, out_instr/out_pc=0.
- FSM states:
  - RUN: no request outstanding.
  - WAIT: request outstanding; imem_req=1, imem_addr held stable until ack.
  - DROP: outstanding request was redirected; next ack is discarded.
- RUN to WAIT: when count<DEPTH and no taken redirect this cycle, register imem_req=1, imem_addr=pc.
- First request appears the first rising edge after Reset deasserts.
- WAIT to RUN on imem_ack:
  - Write {imem_data, imem_addr} into the queue.
  - pc += PC_STEP, modulo 2^ADDR_W, wrap silently.
  - imem_req deasserts in the same edge.
  - Back-to-back issue: if space remains after this write, the next request is issued on the same edge (stays WAIT) for single-cycle memories.
- Taken redirect: BEQ&&Z, BNE&&!Z, JMP, JR. It has priority over everything else in that cycle.
  - pc <= target (JR target: br_base + br_target, modulo 2^ADDR_W).
  - Queue flushed: count=0, out_valid=0 next cycle.
  - From WAIT with no same-cycle ack: go to DROP, imem_req=0.
  - From WAIT with same-cycle ack: ack data dropped, go to RUN.
  - From DROP: stay in DROP, pc updated.
- Not-taken BEQ/BNE: no effect.
- DROP to RUN on imem_ack, data discarded. The request to the new pc issues the following edge.
- Queue behaviour:
  - out_valid = count != 0; head registered.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop allowed at any fill level, including full: count unchanged.
  - No issue while count + outstanding >= DEPTH, so overflow is impossible and imem_ack is never refused.
- Latency: with ack in the same cycle as req, an instruction reaches out_valid two edges after issue.
- imem_ack while in RUN is a protocol error: ignored.

Decomposition:
- fetch_pkg holds:
  - br_mode constants BR_BEQ=2'b00, BR_BNE=2'b01, BR_JMP=2'b10, BR_JR=2'b11.
  - FSM state encoding ST_RUN, ST_WAIT, ST_DROP.
- One sub-module, fetch_queue: DEPTH x (DATA_W+ADDR_W) circular buffer with push, pop, flush, count, and wrap-around read/write pointers.
- PC, redirect and FSM logic stay in the top level.

Test Plan:
- Reset release, imem_ack tied to imem_req, imem_data=0xA0+addr, out_ready=1: imem_addr 0,1,2,3; out_pc/out_instr 0/0xA0, 1/0xA1, ... with no bubbles after the first.
- out_ready=0, single-cycle memory: exactly 4 requests (addr 0..3); imem_req stays 0 and count=4. Raise out_ready: request for addr 4 issues after the first pop.
- Request for addr 5 outstanding, ack delayed 3 cycles; BEQ with Z=1, br_target=0x2: out_valid=0 next cycle; delayed ack data not enqueued; next imem_addr=0x2.
- BNE with Z=1, target 0x40: not taken, sequence continues unchanged. JR with br_base=0x10, br_target=0xFFFFFFFE: next imem_addr=0x0E.
- Redirect (JMP 0x80) in the same cycle as ack: ack data dropped, next imem_addr=0x80, no DROP state entered.
- Reset asserted mid-WAIT with queue holding 3 entries: immediately imem_req=0, out_valid=0, addr=0. After release, fetch restarts at 0.
